// File: rtl/alu_pkg.sv
// Shared opcode/state encodings and default latencies for the ALU operation sequencer.
package alu_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    WAIT = 2'b10,
    DONE = 2'b11
  } seq_state_e;

  localparam int DATA_W_DEF  = 8;
  localparam int MUL_LAT_DEF = 4;
  localparam int DIV_LAT_DEF = 8;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/alu_op_sequencer.sv
// Single-issue request sequencer for the adder/subtractor/multiplier/divider cluster.
// Latches operands, strobes multi-cycle units, waits their latency and holds the result.
//
// state | meaning
// IDLE  | ready for a request
// EXEC  | operands stable at units; single-cycle capture or start strobe
// WAIT  | counting down multi-cycle unit latency
// DONE  | result presented until downstream accepts
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int MUL_LAT = MUL_LAT_DEF,
  parameter int DIV_LAT = DIV_LAT_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [1:0]          in_op,
  input  logic [DATA_W-1:0]   in_a,
  input  logic [DATA_W-1:0]   in_b,
  input  logic                in_cin,
  output logic [DATA_W-1:0]   op_a,
  output logic [DATA_W-1:0]   op_b,
  output logic                op_cin,
  output logic                mul_start,
  output logic                div_start,
  input  logic [DATA_W-1:0]   add_sum,
  input  logic                add_cout,
  input  logic [DATA_W-1:0]   sub_diff,
  input  logic                sub_bout,
  input  logic [2*DATA_W-1:0] mul_prod,
  input  logic [DATA_W-1:0]   div_quot,
  input  logic [DATA_W-1:0]   div_rem,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [2*DATA_W-1:0] out_res,
  output logic                out_err
);

  // Floor of one bit keeps the counter legal when both latencies are 1.
  localparam int CNT_W = (max_int(MUL_LAT, DIV_LAT) > 1) ? $clog2(max_int(MUL_LAT, DIV_LAT)) : 1;

  seq_state_e          state_q, state_d;
  alu_op_e             opc_q, opc_d;
  logic [DATA_W-1:0]   op_a_q, op_a_d;
  logic [DATA_W-1:0]   op_b_q, op_b_d;
  logic                op_cin_q, op_cin_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2*DATA_W-1:0] res_q, res_d;
  logic                err_q, err_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      opc_q    <= OP_ADD;
      op_a_q   <= '0;
      op_b_q   <= '0;
      op_cin_q <= 1'b0;
      cnt_q    <= '0;
      res_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      opc_q    <= opc_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      op_cin_q <= op_cin_d;
      cnt_q    <= cnt_d;
      res_q    <= res_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    opc_d    = opc_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    op_cin_d = op_cin_q;
    cnt_d    = cnt_q;
    res_d    = res_q;
    err_d    = err_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          opc_d    = alu_op_e'(in_op);
          op_a_d   = in_a;
          op_b_d   = in_b;
          op_cin_d = in_cin;
          state_d  = EXEC;
        end
      end
      EXEC: begin
        unique case (opc_q)
          OP_ADD: begin
            res_d   = {{(DATA_W-1){1'b0}}, add_cout, add_sum};
            err_d   = 1'b0;
            state_d = DONE;
          end
          OP_SUB: begin
            res_d   = {{(DATA_W-1){1'b0}}, sub_bout, sub_diff};
            err_d   = 1'b0;
            state_d = DONE;
          end
          OP_MUL: begin
            cnt_d   = CNT_W'(MUL_LAT - 1);
            state_d = WAIT;
          end
          OP_DIV: begin
            // Divide-by-zero never reaches the divider; report dividend and saturated quotient.
            if (op_b_q == '0) begin
              res_d   = {op_a_q, {DATA_W{1'b1}}};
              err_d   = 1'b1;
              state_d = DONE;
            end else begin
              cnt_d   = CNT_W'(DIV_LAT - 1);
              state_d = WAIT;
            end
          end
          default: state_d = IDLE;
        endcase
      end
      WAIT: begin
        if (cnt_q == '0) begin
          res_d   = (opc_q == OP_MUL) ? mul_prod : {div_rem, div_quot};
          err_d   = 1'b0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    mul_start = (state_q == EXEC) && (opc_q == OP_MUL);
    div_start = (state_q == EXEC) && (opc_q == OP_DIV) && (op_b_q != '0);
  end

  assign op_a    = op_a_q;
  assign op_b    = op_b_q;
  assign op_cin  = op_cin_q;
  assign out_res = res_q;
  assign out_err = err_q;

endmodule
